// File: rtl/iter_alu.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
//
// state | meaning
// IDLE  | accepting start; single-cycle ops complete from here
// RUN   | iterating MULTU/DIVU, one bit per clock, start ignored
module iter_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  localparam int H = WIDTH / 2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_BGE   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_LI    = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_MIX   = 4'b1110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] sc_result;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    sc_result = '0;
    case (alucontrol)
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_SLT:  sc_result = ($signed(a) <  $signed(b)) ? WIDTH'(1) : '0;
      OP_BGE:  sc_result = ($signed(a) >= $signed(b)) ? WIDTH'(1) : '0;
      OP_SLL:  sc_result = b << shamt;
      OP_SRL:  sc_result = b >> shamt;
      OP_SRA:  sc_result = $unsigned($signed(b) >>> shamt);
      OP_LUI:  sc_result = {b[H-1:0], {H{1'b0}}};
      OP_LI:   sc_result = {{H{1'b0}}, b[H-1:0]};
      OP_NOR:  sc_result = ~(a | b);
      OP_MIX:  sc_result = {a[WIDTH-1:H], b[H-1:0]};
      default: sc_result = '0;
    endcase
  end

  // Multiply keeps {acc_hi, acc_lo} as the shifting product with the multiplier
  // in the low half; divide keeps remainder in acc_hi and shifts the dividend
  // out of acc_lo while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    iter_hi   = '0;
    iter_lo   = '0;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        iter_hi = div_diff[WIDTH-1:0];
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    valid_d  = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (alucontrol == OP_MULTU || alucontrol == OP_DIVU) begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = (alucontrol == OP_DIVU);
            acc_hi_d = '0;
            if (alucontrol == OP_DIVU) begin
              opnd_d   = b;
              acc_lo_d = a;
            end else begin
              opnd_d   = a;
              acc_lo_d = b;
            end
          end else begin
            valid_d  = 1'b1;
            result_d = sc_result;
            hi_d     = '0;
            zero_d   = (sc_result == '0);
          end
        end
      end
      RUN: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          result_d = iter_lo;
          hi_d     = iter_hi;
          zero_d   = (iter_lo == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign valid  = valid_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: table of single-cycle vectors applied back to back,
// then hand-written multiply/divide, ignored-start and mid-run reset sequences.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, valid, zero;
  logic [31:0] result, hi;

  int total = 0;
  int bad   = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .valid(valid),
    .result(result), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_single(input string nm, input logic [3:0] op, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] exp_r);
    @(negedge clk);
    alucontrol = op; a = av; b = bv; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " valid"}, 32'(valid), 32'd1);
    check({nm, " result"}, result, exp_r);
    check({nm, " hi"}, hi, 32'd0);
    check({nm, " zero"}, 32'(zero), 32'(exp_r == 32'd0));
  endtask

  task automatic run_multi(input string nm, input logic [3:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_r,
                           input logic [31:0] exp_h, input bit poke);
    int n;
    @(negedge clk);
    alucontrol = op; a = av; b = bv; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " busy after start"}, 32'(busy), 32'd1);
    check({nm, " no early valid"}, 32'(valid), 32'd0);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      if (poke && n == 9) begin
        start = 1'b1; alucontrol = 4'b0010; a = 32'd0; b = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      n++;
      if (poke && n == 10) check({nm, " busy after ignored start"}, 32'(busy), 32'd1);
    end
    check({nm, " latency"}, n, 32'd32);
    check({nm, " valid"}, 32'(valid), 32'd1);
    check({nm, " busy done"}, 32'(busy), 32'd0);
    check({nm, " result"}, result, exp_r);
    check({nm, " hi"}, hi, exp_h);
    check({nm, " zero"}, 32'(zero), 32'(exp_r == 32'd0));
    @(posedge clk); #1;
    check({nm, " valid pulse"}, 32'(valid), 32'd0);
    check({nm, " result hold"}, result, exp_r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcount;
    vecs[0]  = '{"add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000};
    vecs[1]  = '{"slt_neg",   4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vecs[2]  = '{"bge_neg",   4'b0101, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0000};
    vecs[3]  = '{"sub_eq",    4'b0110, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000};
    vecs[4]  = '{"sra4",      4'b1101, 32'h0,         32'hF000_0000, 5'd4,  32'hFF00_0000};
    vecs[5]  = '{"srl4",      4'b1010, 32'h0,         32'hF000_0000, 5'd4,  32'h0F00_0000};
    vecs[6]  = '{"lui",       4'b1011, 32'h0,         32'h0000_1234, 5'd0,  32'h1234_0000};
    vecs[7]  = '{"and",       4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000};
    vecs[8]  = '{"or",        4'b0001, 32'h0F0F_0000, 32'h0000_00FF, 5'd0,  32'h0F0F_00FF};
    vecs[9]  = '{"nor0",      4'b1100, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF};
    vecs[10] = '{"nor1",      4'b1100, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0,  32'h0000_0000};
    vecs[11] = '{"sll31",     4'b1000, 32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[12] = '{"li",        4'b1001, 32'h0,         32'hABCD_1234, 5'd0,  32'h0000_1234};
    vecs[13] = '{"mix",       4'b1110, 32'hAAAA_5555, 32'h1234_CDEF, 5'd0,  32'hAAAA_CDEF};
    vecs[14] = '{"op1111",    4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
    vecs[15] = '{"slt_ovf",   4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0,  32'h0000_0000};
    vecs[16] = '{"bge_ovf",   4'b0101, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0,  32'h0000_0001};
    vecs[17] = '{"slt_m1",    4'b0111, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'h0000_0001};
    vecs[18] = '{"bge_eq",    4'b0101, 32'h0000_0003, 32'h0000_0003, 5'd0,  32'h0000_0001};
    vecs[19] = '{"add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    vecs[20] = '{"sub_wrap",  4'b0110, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF};
    vecs[21] = '{"sra0",      4'b1101, 32'h0,         32'h8000_0000, 5'd0,  32'h8000_0000};
    vecs[22] = '{"sra_pos31", 4'b1101, 32'h0,         32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[23] = '{"srl31",     4'b1010, 32'h0,         32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[24] = '{"sra_neg31", 4'b1101, 32'h0,         32'h8000_0000, 5'd31, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; alucontrol = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back single-cycle ops: one start per cycle, valid every cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      alucontrol = vecs[i].op; a = vecs[i].a; b = vecs[i].b; shamt = vecs[i].sh; start = 1'b1;
      @(posedge clk); #1;
      check({vecs[i].name, " valid"}, 32'(valid), 32'd1);
      check({vecs[i].name, " result"}, result, vecs[i].res);
      check({vecs[i].name, " hi"}, hi, 32'd0);
      check({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].res == 32'd0));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle valid low", 32'(valid), 32'd0);
    check("idle result hold", result, vecs[NV-1].res);

    run_multi("multu_max", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_multi("multu_2^32", 4'b0011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_multi("divu_100_7", 4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    run_single("and_after_div", 4'b0000, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_00F0);
    run_multi("divu_by0", 4'b0100, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b0);
    run_multi("divu_max_10", 4'b0100, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 1'b0);

    // Reset in the middle of a multiply abandons it without a valid.
    @(negedge clk);
    alucontrol = 4'b0011; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset result", result, 32'd0);
    check("midrun reset hi", hi, 32'd0);
    check("midrun reset zero", 32'(zero), 32'd1);
    check("midrun reset valid", 32'(valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) vcount++;
    end
    check("no valid after reset", vcount, 32'd0);
    check("idle busy after reset", 32'(busy), 32'd0);
    run_single("add_after_reset", 4'b0010, 32'd2, 32'd3, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds logical and arithmetic right shifts, a corrected signed compare, and iterative unsigned multiply/divide. Multiply/divide return a high word (product high half / remainder).
- Sits in the execute stage of the multicycle processor. The controller issues work with start/busy/valid and stalls while busy.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- alucontrol  input  4  operation select, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- shamt  input  SHW  shift amount, sampled with start.
- busy  output  1  iterative operation in progress.
- valid  output  1  one-cycle pulse: result/hi/zero updated this cycle.
- result  output  WIDTH  primary result (product low half / quotient).
- hi  output  WIDTH  product high half / remainder; 0 for all other ops.
- zero  output  1  result == 0, registered with result.

Behaviour:
- Reset (async, immediate): FSM=IDLE, busy=0, valid=0, result=0, hi=0, zero=1, cycle counter=0.
- FSM states: IDLE, RUN.
  - IDLE with start=1 and a single-cycle op: registers result/hi/zero and raises valid on the next edge; stays IDLE. Latency 1.
  - IDLE with start=1 and MULTU/DIVU: latches operands; busy=1 from the next edge; enters RUN with counter=0.
  - RUN: one iteration per cycle. After WIDTH iterations, at the edge where counter=WIDTH-1, writes result/hi/zero, valid=1, busy=0, returns to IDLE.
  - Total latency: valid is asserted WIDTH cycles after the start edge (32 for WIDTH=32).
- start while busy=1 is ignored; no queueing, and the in-flight operation is unaffected.
- valid is high for exactly one cycle per accepted op.
- result, hi and zero hold their values until the next valid. Back-to-back single-cycle starts give valid on consecutive cycles.
- Operation codes. All arithmetic wraps modulo 2^WIDTH. H = WIDTH/2. hi=0 except where noted.
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b.
  - 0110 SUB: a - b.
  - 0111 SLT: signed a < signed b ? 1 : 0. True signed compare, correct on overflow.
  - 0101 BGE flag: signed a >= signed b ? 1 : 0.
  - 1000 SLL: b << shamt.
  - 1010 SRL: b >> shamt, zero fill.
  - 1101 SRA: b >>> shamt, sign fill.
  - 1011 LUI: b[H-1:0] placed in the upper half, lower half 0.
  - 1001 LI: zero-extended b[H-1:0].
  - 1100 NOR: ~(a | b).
  - 1110 MIX: {a[WIDTH-1:H], b[H-1:0]}.
  - 0011 MULTU: unsigned shift-add, 2*WIDTH-bit product; result=low half, hi=high half.
  - 0100 DIVU: unsigned restoring division, 1 quotient bit per cycle; result=quotient, hi=remainder.
  - 1111 and any other unlisted code: single-cycle, result=0, hi=0.
- DIVU with b=0: same latency; result=all ones, hi=a. No exception output.
- Reset asserted mid-RUN: the operation is abandoned, all outputs go to their reset values, and no valid is produced.
- Operands are latched at acceptance; input changes during RUN have no effect.

Test Plan:
- Reset, then ADD with a=32'h7FFF_FFFF, b=1 -> one cycle later: valid=1, result=32'h8000_0000, zero=0, hi=0.
- SLT with a=32'h8000_0000, b=1 -> result=1. BGE, same operands -> result=0. SUB with a=5, b=5 -> result=0, zero=1.
- SRA with b=32'hF000_0000, shamt=4 -> result=32'hFF00_0000. SRL, same inputs -> result=32'h0F00_0000. LUI with b=32'h0000_1234 -> result=32'h1234_0000.
- MULTU with a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> busy for 32 cycles; valid exactly 32 cycles after start; result=32'h0000_0001, hi=32'hFFFF_FFFE. A start pulse at cycle 10 is ignored.
- DIVU with a=100, b=7 -> result=14, hi=2. DIVU with a=100, b=0 -> result=32'hFFFF_FFFF, hi=100.
- MULTU started, reset pulsed at cycle 5 -> busy=0, result=0, zero=1 immediately; no valid afterwards. A fresh ADD then completes normally.
